// File: rtl/gpu_video_pkg.sv
// Shared video/framebuffer geometry and the fixed-point to 8-bit grey conversion
// used by the scanout path.
package gpu_video_pkg;

    localparam int H_ACTIVE      = 1280;
    localparam int V_ACTIVE      = 720;
    localparam int SCALE_SHIFT   = 2;
    localparam int FB_WIDTH      = H_ACTIVE >> SCALE_SHIFT;
    localparam int FB_HEIGHT     = V_ACTIVE >> SCALE_SHIFT;
    localparam int FB_SIZE       = FB_WIDTH * FB_HEIGHT;
    localparam int WORD_WIDTH    = 16;
    localparam int FIXED_POINT   = 10;
    localparam int FB_ADDR_WIDTH = $clog2(2 * FB_SIZE);

    // Clamp to [0, 1.0) and keep the top 8 fractional bits.
    function automatic logic [7:0] fixed_to_u8(input logic signed [WORD_WIDTH-1:0] w);
        if (w < 0) begin
            return 8'd0;
        end
        if (int'(w) >= (1 << FIXED_POINT)) begin
            return 8'd255;
        end
        return w[FIXED_POINT-1 -: 8];
    endfunction

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Framebuffer read port: address/enable out of the scanout, read data back in.
interface framebuffer_scanout_if
    import gpu_video_pkg::*;
();

    logic [FB_ADDR_WIDTH-1:0] fb_addr_out;
    logic                     fb_rd_en_out;
    logic [WORD_WIDTH-1:0]    fb_data_in;

    modport master (
        output fb_addr_out,
        output fb_rd_en_out,
        input  fb_data_in
    );

    modport slave (
        input  fb_addr_out,
        input  fb_rd_en_out,
        output fb_data_in
    );

endinterface

// File: rtl/sync_delay.sv
// Parameterized shift register with synchronous clear; keeps syncs aligned with
// pixel data coming back through the memory and convert stages.
module sync_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_d[gi] = din;
            end else begin : g_next
                assign stage_d[gi] = stage_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (srst) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/framebuffer_scanout.sv
// Pixel-domain scanout: maps raster position to framebuffer reads with 4x
// replication, converts words to grey, and owns front/back buffer swapping.
module framebuffer_scanout
    import gpu_video_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic                     clk_pixel_in,
    input  logic                     rst_in,
    input  logic [10:0]              hcount_in,
    input  logic [9:0]               vcount_in,
    input  logic                     hs_in,
    input  logic                     vs_in,
    input  logic                     ad_in,
    input  logic                     nf_in,
    input  logic                     swap_req_in,
    framebuffer_scanout_if.master    fb,
    output logic [FB_ADDR_WIDTH-1:0] back_base_out,
    output logic                     swap_done_out,
    output logic [7:0]               red_out,
    output logic [7:0]               green_out,
    output logic [7:0]               blue_out,
    output logic                     hs_out,
    output logic                     vs_out,
    output logic                     ad_out
);

    localparam int LAT = READ_LATENCY + 2;

    typedef logic [FB_ADDR_WIDTH-1:0] addr_t;

    addr_t      fb_addr_q, fb_addr_d;
    addr_t      back_base_q, back_base_d;
    addr_t      front_base;
    logic       fb_rd_en_q, fb_rd_en_d;
    logic       buf_sel_q, buf_sel_d;
    logic       pend_q, pend_d;
    logic       swap_done_q, swap_done_d;
    logic [7:0] grey_q, grey_d;
    logic [2:0] sync_dly;

    always_comb begin
        front_base  = buf_sel_q ? addr_t'(FB_SIZE) : '0;
        fb_addr_d   = front_base
                    + addr_t'(vcount_in >> SCALE_SHIFT) * addr_t'(FB_WIDTH)
                    + addr_t'(hcount_in >> SCALE_SHIFT);
        fb_rd_en_d  = ad_in;
        grey_d      = fixed_to_u8(fb.fb_data_in);

        buf_sel_d   = buf_sel_q;
        pend_d      = pend_q;
        swap_done_d = 1'b0;
        // A request landing on the frame boundary itself still swaps this frame.
        if (nf_in && (pend_q || swap_req_in)) begin
            buf_sel_d   = ~buf_sel_q;
            pend_d      = 1'b0;
            swap_done_d = 1'b1;
        end else if (swap_req_in) begin
            pend_d = 1'b1;
        end
        back_base_d = buf_sel_d ? '0 : addr_t'(FB_SIZE);
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            fb_addr_q   <= '0;
            fb_rd_en_q  <= 1'b0;
            grey_q      <= '0;
            buf_sel_q   <= 1'b0;
            pend_q      <= 1'b0;
            swap_done_q <= 1'b0;
            back_base_q <= addr_t'(FB_SIZE);
        end else begin
            fb_addr_q   <= fb_addr_d;
            fb_rd_en_q  <= fb_rd_en_d;
            grey_q      <= grey_d;
            buf_sel_q   <= buf_sel_d;
            pend_q      <= pend_d;
            swap_done_q <= swap_done_d;
            back_base_q <= back_base_d;
        end
    end

    sync_delay #(
        .WIDTH (3),
        .DEPTH (LAT)
    ) u_sync_delay (
        .clk  (clk_pixel_in),
        .srst (rst_in),
        .din  ({hs_in, vs_in, ad_in}),
        .dout (sync_dly)
    );

    assign fb.fb_addr_out  = fb_addr_q;
    assign fb.fb_rd_en_out = fb_rd_en_q;
    assign back_base_out   = back_base_q;
    assign swap_done_out   = swap_done_q;
    assign hs_out          = sync_dly[2];
    assign vs_out          = sync_dly[1];
    assign ad_out          = sync_dly[0];
    // Blank outside the delayed active area regardless of what memory returned.
    assign red_out         = sync_dly[0] ? grey_q : 8'd0;
    assign green_out       = sync_dly[0] ? grey_q : 8'd0;
    assign blue_out        = sync_dly[0] ? grey_q : 8'd0;

endmodule
